// File: rtl/cpu_pkg.sv
// Purpose: shared register-file constants for the writeback path.
// Latency: n/a (constants only).
// Backpressure: n/a.
package cpu_pkg;

    localparam int REG_AW  = 5;
    localparam int REG_NUM = 32;
    localparam int XLEN    = 32;

    localparam logic [REG_AW-1:0] ZERO_REG = 5'd0;

endpackage : cpu_pkg

// File: rtl/rr_arbiter.sv
// Purpose: combinational round-robin pick, scanning req from ptr upward with wrap.
// Latency: zero cycles, purely combinational; the pointer register lives in the parent.
// Backpressure: grant is one-hot on the first valid request, all-zero when none is valid.
module rr_arbiter #(
    parameter  int N  = 3,
    localparam int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic [PW-1:0] grant_idx
);

    // Walk the requesters starting at ptr; the first valid one wins.
    always_comb begin
        int   idx;
        logic found;
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        idx       = 0;
        for (int k = 0; k < N; k++) begin
            idx = int'(ptr) + k;
            if (idx >= N) begin
                idx = idx - N;
            end
            if (!found && req[idx]) begin
                found      = 1'b1;
                grant[idx] = 1'b1;
                grant_idx  = PW'(idx);
            end
        end
    end

endmodule : rr_arbiter

// File: rtl/regfile_write_arbiter.sv
// Purpose: shares the register file write port among NREQ writeback sources and tracks pending writes.
// Latency: request accepted in cycle N drives rf_we/rf_wa/rf_wd in N+1; one write per cycle sustained.
// Backpressure: req_ready is the one-hot round-robin grant; a requester holds valid/addr/data until granted.
module regfile_write_arbiter
    import cpu_pkg::*;
#(
    parameter int WIDTH = XLEN,
    parameter int NREQ  = 3,
    parameter int AW    = REG_AW
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NREQ-1:0]    req_valid,
    output logic [NREQ-1:0]    req_ready,
    input  logic [NREQ*AW-1:0] req_addr,
    input  logic [NREQ*WIDTH-1:0] req_data,
    output logic               rf_we,
    output logic [AW-1:0]      rf_wa,
    output logic [WIDTH-1:0]   rf_wd,
    input  logic               rsv_valid,
    input  logic [AW-1:0]      rsv_addr,
    input  logic [AW-1:0]      qa1,
    input  logic [AW-1:0]      qa2,
    output logic               busy1,
    output logic               busy2,
    input  logic               flush
);

    localparam int PW   = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int NREG = 1 << AW;

    logic [PW-1:0]    rr_ptr_q, rr_ptr_d;
    logic             rf_we_q, rf_we_d;
    logic [AW-1:0]    rf_wa_q, rf_wa_d;
    logic [WIDTH-1:0] rf_wd_q, rf_wd_d;
    logic [NREG-1:0]  busy_q, busy_d;

    logic [NREQ-1:0]  arb_grant;
    logic [PW-1:0]    arb_idx;
    logic             xfer;
    logic [AW-1:0]    sel_addr;
    logic [WIDTH-1:0] sel_data;

    rr_arbiter #(
        .N (NREQ)
    ) u_rr_arbiter (
        .req       (req_valid),
        .ptr       (rr_ptr_q),
        .grant     (arb_grant),
        .grant_idx (arb_idx)
    );

    // Grants are suppressed during reset so nothing transfers on a reset edge.
    assign req_ready = rst ? '0 : arb_grant;
    assign xfer      = |req_ready;
    assign sel_addr  = req_addr[arb_idx*AW +: AW];
    assign sel_data  = req_data[arb_idx*WIDTH +: WIDTH];

    // Output stage and pointer: capture the winner; r0 writes are accepted but never enabled.
    always_comb begin
        rf_we_d  = 1'b0;
        rf_wa_d  = rf_wa_q;
        rf_wd_d  = rf_wd_q;
        rr_ptr_d = rr_ptr_q;
        if (xfer) begin
            rf_we_d  = (sel_addr != '0);
            rf_wa_d  = sel_addr;
            rf_wd_d  = sel_data;
            rr_ptr_d = (arb_idx == PW'(NREQ - 1)) ? '0 : arb_idx + 1'b1;
        end
    end

    // Scoreboard update: flush, then commit-clear, then reservation, so a new reservation wins.
    always_comb begin
        busy_d = busy_q;
        if (flush) begin
            busy_d = '0;
        end
        if (rf_we_q) begin
            busy_d[rf_wa_q] = 1'b0;
        end
        if (rsv_valid && (rsv_addr != '0)) begin
            busy_d[rsv_addr] = 1'b1;
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            rf_we_q  <= 1'b0;
            rf_wa_q  <= '0;
            rf_wd_q  <= '0;
            rr_ptr_q <= '0;
            busy_q   <= '0;
        end else begin
            rf_we_q  <= rf_we_d;
            rf_wa_q  <= rf_wa_d;
            rf_wd_q  <= rf_wd_d;
            rr_ptr_q <= rr_ptr_d;
            busy_q   <= busy_d;
        end
    end

    assign rf_we = rf_we_q;
    assign rf_wa = rf_wa_q;
    assign rf_wd = rf_wd_q;

    // Hazard lookups; r0 never reports busy.
    assign busy1 = (qa1 != '0) && busy_q[qa1];
    assign busy2 = (qa2 != '0) && busy_q[qa2];

endmodule : regfile_write_arbiter

// File: tb/tb_regfile_write_arbiter.sv
// Purpose: directed self-checking bench for regfile_write_arbiter (NREQ=3, AW=5, WIDTH=32).
// Latency: checks registered outputs 1 ns after each rising edge, combinational ones 2 ns after.
// Backpressure: requesters are held valid until granted, as a real source would.
module tb_regfile_write_arbiter;

    localparam int NREQ  = 3;
    localparam int AW    = 5;
    localparam int WIDTH = 32;

    logic                     clk = 1'b0;
    logic                     rst;
    logic [NREQ-1:0]          req_valid;
    logic [NREQ-1:0]          req_ready;
    logic [NREQ*AW-1:0]       req_addr;
    logic [NREQ*WIDTH-1:0]    req_data;
    logic                     rf_we;
    logic [AW-1:0]            rf_wa;
    logic [WIDTH-1:0]         rf_wd;
    logic                     rsv_valid;
    logic [AW-1:0]            rsv_addr;
    logic [AW-1:0]            qa1;
    logic [AW-1:0]            qa2;
    logic                     busy1;
    logic                     busy2;
    logic                     flush;

    int errors = 0;
    int checks = 0;

    regfile_write_arbiter #(
        .WIDTH (WIDTH),
        .NREQ  (NREQ),
        .AW    (AW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_addr  (req_addr),
        .req_data  (req_data),
        .rf_we     (rf_we),
        .rf_wa     (rf_wa),
        .rf_wd     (rf_wd),
        .rsv_valid (rsv_valid),
        .rsv_addr  (rsv_addr),
        .qa1       (qa1),
        .qa2       (qa2),
        .busy1     (busy1),
        .busy2     (busy2),
        .flush     (flush)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic v, input logic [AW-1:0] a, input logic [WIDTH-1:0] d);
        req_valid[i]              = v;
        req_addr[i*AW +: AW]       = a;
        req_data[i*WIDTH +: WIDTH] = d;
    endtask

    initial begin
        rst       = 1'b1;
        req_valid = '0;
        req_addr  = '0;
        req_data  = '0;
        rsv_valid = 1'b0;
        rsv_addr  = '0;
        qa1       = 5'd7;
        qa2       = 5'd31;
        flush     = 1'b0;

        // Reset: two cycles; ready must stay low even with requests present.
        tick();
        req_valid = 3'b111;
        #1;
        chk("ready_in_reset", 32'(req_ready), 32'h0);
        tick();
        rst       = 1'b0;
        req_valid = '0;
        #1;
        chk("rst_we", 32'(rf_we), 32'h0);
        chk("rst_wa", 32'(rf_wa), 32'h0);
        chk("rst_wd", rf_wd, 32'h0);
        chk("rst_busy1", 32'(busy1), 32'h0);
        chk("rst_busy2", 32'(busy2), 32'h0);
        chk("rst_ready_idle", 32'(req_ready), 32'h0);

        // Single write from requester 1 (pointer 0 -> scan finds 1).
        set_req(1, 1'b1, 5'd5, 32'hDEADBEEF);
        #1;
        chk("single_ready", 32'(req_ready), 32'h2);
        tick();
        set_req(1, 1'b0, 5'd0, 32'h0);
        chk("single_we", 32'(rf_we), 32'h1);
        chk("single_wa", 32'(rf_wa), 32'h5);
        chk("single_wd", rf_wd, 32'hDEADBEEF);
        tick();
        chk("single_we_drop", 32'(rf_we), 32'h0);
        chk("single_wa_hold", 32'(rf_wa), 32'h5);

        // Pointer now 2: a lone requester 2 write brings it back to 0.
        set_req(2, 1'b1, 5'd4, 32'h44);
        #1;
        chk("ptr2_ready", 32'(req_ready), 32'h4);
        tick();
        set_req(2, 1'b0, 5'd0, 32'h0);
        chk("ptr2_wa", 32'(rf_wa), 32'h4);

        // Round-robin: all three valid for six cycles.
        for (int i = 0; i < NREQ; i++) begin
            set_req(i, 1'b1, 5'(i + 1), 32'h100 + 32'(i));
        end
        for (int k = 0; k < 6; k++) begin
            #1;
            chk("rr_grant", 32'(req_ready), 32'(1 << (k % 3)));
            tick();
            chk("rr_we", 32'(rf_we), 32'h1);
            chk("rr_wa", 32'(rf_wa), 32'((k % 3) + 1));
            chk("rr_wd", rf_wd, 32'h100 + 32'(k % 3));
        end
        req_valid = '0;

        // r0 write from requester 0: accepted, no enable, scoreboard untouched.
        qa1 = 5'd0;
        set_req(0, 1'b1, 5'd0, 32'h1234);
        #1;
        chk("r0_ready", 32'(req_ready), 32'h1);
        tick();
        set_req(0, 1'b0, 5'd0, 32'h0);
        chk("r0_we", 32'(rf_we), 32'h0);
        chk("r0_wa", 32'(rf_wa), 32'h0);
        chk("r0_wd", rf_wd, 32'h1234);
        chk("r0_busy1", 32'(busy1), 32'h0);

        // Scoreboard: reserve 7, then commit a write to 7 (pointer is 1).
        qa1       = 5'd7;
        rsv_valid = 1'b1;
        rsv_addr  = 5'd7;
        #1;
        chk("sb_busy_N", 32'(busy1), 32'h0);
        tick();
        rsv_valid = 1'b0;
        chk("sb_busy_N1", 32'(busy1), 32'h1);
        set_req(1, 1'b1, 5'd7, 32'hAA);
        #1;
        chk("sb_wr_ready", 32'(req_ready), 32'h2);
        tick();
        set_req(1, 1'b0, 5'd0, 32'h0);
        chk("sb_we_M1", 32'(rf_we), 32'h1);
        chk("sb_busy_M1", 32'(busy1), 32'h1);
        tick();
        chk("sb_busy_M2", 32'(busy1), 32'h0);

        // Same-edge reserve and commit of 7: the reservation survives (pointer is 2).
        rsv_valid = 1'b1;
        rsv_addr  = 5'd7;
        tick();
        rsv_valid = 1'b0;
        chk("sb2_busy", 32'(busy1), 32'h1);
        set_req(2, 1'b1, 5'd7, 32'hBB);
        #1;
        chk("sb2_ready", 32'(req_ready), 32'h4);
        tick();
        set_req(2, 1'b0, 5'd0, 32'h0);
        chk("sb2_we", 32'(rf_we), 32'h1);
        rsv_valid = 1'b1;
        rsv_addr  = 5'd7;
        tick();
        rsv_valid = 1'b0;
        chk("sb2_busy_same_edge", 32'(busy1), 32'h1);
        tick();
        chk("sb2_busy_held", 32'(busy1), 32'h1);

        // Flush: reserve 3 and 9, then flush with a new reservation of 9 and a write in flight.
        qa1       = 5'd3;
        qa2       = 5'd9;
        rsv_valid = 1'b1;
        rsv_addr  = 5'd3;
        tick();
        rsv_addr  = 5'd9;
        tick();
        rsv_valid = 1'b0;
        chk("fl_pre_busy3", 32'(busy1), 32'h1);
        chk("fl_pre_busy9", 32'(busy2), 32'h1);
        flush     = 1'b1;
        rsv_valid = 1'b1;
        rsv_addr  = 5'd9;
        set_req(0, 1'b1, 5'd12, 32'h5);
        #1;
        chk("fl_ready", 32'(req_ready), 32'h1);
        tick();
        flush     = 1'b0;
        rsv_valid = 1'b0;
        set_req(0, 1'b0, 5'd0, 32'h0);
        chk("fl_busy3", 32'(busy1), 32'h0);
        chk("fl_busy9", 32'(busy2), 32'h1);
        chk("fl_we", 32'(rf_we), 32'h1);
        chk("fl_wa", 32'(rf_wa), 32'hC);

        // Reset in the grant cycle: pointer is 1, so requester 1 would win.
        for (int i = 0; i < NREQ; i++) begin
            set_req(i, 1'b1, 5'(i + 1), 32'h200 + 32'(i));
        end
        #1;
        chk("mr_ready_pre", 32'(req_ready), 32'h2);
        rst = 1'b1;
        #1;
        chk("mr_ready_rst", 32'(req_ready), 32'h0);
        tick();
        rst = 1'b0;
        chk("mr_we", 32'(rf_we), 32'h0);
        chk("mr_busy9", 32'(busy2), 32'h0);
        #1;
        chk("mr_ptr0_ready", 32'(req_ready), 32'h1);
        tick();
        req_valid = '0;
        chk("mr_wa", 32'(rf_wa), 32'h1);
        chk("mr_wd", rf_wd, 32'h200);

        tick();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Hard stop in case the sequence above ever stalls.
    initial begin
        #20000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule : tb_regfile_write_arbiter
